// File: rtl/adder_pkg.sv
// Shared constants and result type for the multi-topology adder library.
// Defaults here seed the top-level parameters; the struct mirrors one {carry, sum} pair.
package adder_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_CLA_BLOCK_WIDTH = 4;
  localparam int DEFAULT_CKA_BLOCK_WIDTH = 4;
  localparam int DEFAULT_CSA_BLOCK_WIDTH = 4;

  typedef struct packed {
    logic                          carry;
    logic [DEFAULT_DATA_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/adder_pg_block.sv
// WIDTH-bit ripple adder block exposing per-bit and group generate/propagate.
// Shared building block for the lookahead, skip and select adder chains.
module adder_pg_block #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p,
  output logic             cout,
  output logic             grp_g,
  output logic             grp_p
);

  logic [WIDTH:0] carry;
  logic [WIDTH:0] gen_chain;

  assign g = a & b;
  assign p = a ^ b;

  // NOTE: every variable written here gets a value before any branch or loop, so no latch can be inferred.
  always_comb begin
    carry        = '0;
    gen_chain    = '0;
    carry[0]     = cin;
    gen_chain[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1]     = g[i] | (p[i] & carry[i]);
      gen_chain[i+1] = g[i] | (p[i] & gen_chain[i]);
    end
  end

  assign sum   = p ^ carry[WIDTH-1:0];
  assign cout  = carry[WIDTH];
  assign grp_g = gen_chain[WIDTH];
  assign grp_p = &p;

endmodule

// File: rtl/multi_topology_adder.sv
// Registered A+B+Cin computed by carry-lookahead, carry-skip and carry-select chains
// in parallel, with a flag raised whenever the three registered results disagree.
module multi_topology_adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int CLA_BLOCK_WIDTH = DEFAULT_CLA_BLOCK_WIDTH,
  parameter int CKA_BLOCK_WIDTH = DEFAULT_CKA_BLOCK_WIDTH,
  parameter int CSA_BLOCK_WIDTH = DEFAULT_CSA_BLOCK_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic                  carry_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] cla_result_o,
  output logic                  cla_carry_o,
  output logic [DATA_WIDTH-1:0] cka_result_o,
  output logic                  cka_carry_o,
  output logic [DATA_WIDTH-1:0] csa_result_o,
  output logic                  csa_carry_o,
  output logic                  mismatch_o
);

  localparam int CLA_GROUPS = DATA_WIDTH / CLA_BLOCK_WIDTH;
  localparam int CKA_BLOCKS = DATA_WIDTH / CKA_BLOCK_WIDTH;
  localparam int CSA_BLOCKS = DATA_WIDTH / CSA_BLOCK_WIDTH;

  if (DATA_WIDTH % CLA_BLOCK_WIDTH != 0) begin : g_cla_width_check
    $error("DATA_WIDTH must be a multiple of CLA_BLOCK_WIDTH");
  end
  if (DATA_WIDTH % CKA_BLOCK_WIDTH != 0) begin : g_cka_width_check
    $error("DATA_WIDTH must be a multiple of CKA_BLOCK_WIDTH");
  end
  if (DATA_WIDTH % CSA_BLOCK_WIDTH != 0) begin : g_csa_width_check
    $error("DATA_WIDTH must be a multiple of CSA_BLOCK_WIDTH");
  end

  // Carry-lookahead: in-group carries are flat sum-of-products of g/p and the group carry-in.
  logic [CLA_GROUPS:0]   cla_gc;
  logic [DATA_WIDTH-1:0] cla_sum;
  assign cla_gc[0] = carry_i;

  for (genvar gi = 0; gi < CLA_GROUPS; gi++) begin : g_cla
    localparam int LSB = gi * CLA_BLOCK_WIDTH;
    logic [CLA_BLOCK_WIDTH-1:0] g, p, c, unused_sum;
    logic                       grp_g, grp_p, unused_cout;
    logic                       acc, prod;

    adder_pg_block #(.WIDTH(CLA_BLOCK_WIDTH)) u_pg (
      .a(operand_A_i[LSB +: CLA_BLOCK_WIDTH]), .b(operand_B_i[LSB +: CLA_BLOCK_WIDTH]),
      .cin(cla_gc[gi]), .sum(unused_sum), .g(g), .p(p),
      .cout(unused_cout), .grp_g(grp_g), .grp_p(grp_p)
    );

    always_comb begin
      c    = '0;
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = 0; j < CLA_BLOCK_WIDTH; j++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int k = j - 1; k >= 0; k--) begin
          acc  = acc | (g[k] & prod);
          prod = prod & p[k];
        end
        c[j] = acc | (prod & cla_gc[gi]);
      end
    end

    assign cla_sum[LSB +: CLA_BLOCK_WIDTH] = p ^ c;
    assign cla_gc[gi+1] = grp_g | (grp_p & cla_gc[gi]);
  end

  // Carry-skip: a fully propagating block forwards its carry-in past the ripple.
  logic [CKA_BLOCKS:0]   cka_c;
  logic [DATA_WIDTH-1:0] cka_sum;
  assign cka_c[0] = carry_i;

  for (genvar bi = 0; bi < CKA_BLOCKS; bi++) begin : g_cka
    localparam int LSB = bi * CKA_BLOCK_WIDTH;
    logic [CKA_BLOCK_WIDTH-1:0] unused_g, unused_p;
    logic                       rip_cout, grp_p, unused_grp_g;

    adder_pg_block #(.WIDTH(CKA_BLOCK_WIDTH)) u_pg (
      .a(operand_A_i[LSB +: CKA_BLOCK_WIDTH]), .b(operand_B_i[LSB +: CKA_BLOCK_WIDTH]),
      .cin(cka_c[bi]), .sum(cka_sum[LSB +: CKA_BLOCK_WIDTH]), .g(unused_g), .p(unused_p),
      .cout(rip_cout), .grp_g(unused_grp_g), .grp_p(grp_p)
    );

    assign cka_c[bi+1] = grp_p ? cka_c[bi] : rip_cout;
  end

  logic [CSA_BLOCKS:0]   csa_c;
  logic [DATA_WIDTH-1:0] csa_sum;
  assign csa_c[0] = carry_i;

  for (genvar bi = 0; bi < CSA_BLOCKS; bi++) begin : g_csa
    localparam int LSB = bi * CSA_BLOCK_WIDTH;
    logic [1:0][CSA_BLOCK_WIDTH-1:0] sum_pre, unused_g, unused_p;
    logic [1:0]                      cout_pre, unused_grp_g, unused_grp_p;

    if (bi == 0) begin : g_first
      adder_pg_block #(.WIDTH(CSA_BLOCK_WIDTH)) u_pg (
        .a(operand_A_i[LSB +: CSA_BLOCK_WIDTH]), .b(operand_B_i[LSB +: CSA_BLOCK_WIDTH]),
        .cin(carry_i), .sum(sum_pre[0]), .g(unused_g[0]), .p(unused_p[0]),
        .cout(cout_pre[0]), .grp_g(unused_grp_g[0]), .grp_p(unused_grp_p[0])
      );
      assign sum_pre[1]      = '0;
      assign unused_g[1]     = '0;
      assign unused_p[1]     = '0;
      assign cout_pre[1]     = 1'b0;
      assign unused_grp_g[1] = 1'b0;
      assign unused_grp_p[1] = 1'b0;
      assign csa_sum[LSB +: CSA_BLOCK_WIDTH] = sum_pre[0];
      assign csa_c[bi+1] = cout_pre[0];
    end else begin : g_pair
      for (genvar ci = 0; ci < 2; ci++) begin : g_cin
        adder_pg_block #(.WIDTH(CSA_BLOCK_WIDTH)) u_pg (
          .a(operand_A_i[LSB +: CSA_BLOCK_WIDTH]), .b(operand_B_i[LSB +: CSA_BLOCK_WIDTH]),
          .cin(ci[0]), .sum(sum_pre[ci]), .g(unused_g[ci]), .p(unused_p[ci]),
          .cout(cout_pre[ci]), .grp_g(unused_grp_g[ci]), .grp_p(unused_grp_p[ci])
        );
      end
      assign csa_sum[LSB +: CSA_BLOCK_WIDTH] = csa_c[bi] ? sum_pre[1] : sum_pre[0];
      assign csa_c[bi+1] = csa_c[bi] ? cout_pre[1] : cout_pre[0];
    end
  end

  logic [DATA_WIDTH:0] cla_d, cka_d, csa_d;
  logic [DATA_WIDTH:0] cla_q, cka_q, csa_q;
  logic                valid_q, mismatch_q;

  assign cla_d = {cla_gc[CLA_GROUPS], cla_sum};
  assign cka_d = {cka_c[CKA_BLOCKS], cka_sum};
  assign csa_d = {csa_c[CSA_BLOCKS], csa_sum};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cla_q      <= '0;
      cka_q      <= '0;
      csa_q      <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      valid_q    <= valid_i;
      mismatch_q <= valid_i && ((cla_d != cka_d) || (cla_d != csa_d));
      if (valid_i) begin
        cla_q <= cla_d;
        cka_q <= cka_d;
        csa_q <= csa_d;
      end
    end
  end

  assign valid_o                     = valid_q;
  assign mismatch_o                  = mismatch_q;
  assign {cla_carry_o, cla_result_o} = cla_q;
  assign {cka_carry_o, cka_result_o} = cka_q;
  assign {csa_carry_o, csa_result_o} = csa_q;

endmodule

// File: tb/tb_multi_topology_adder.sv
// Scoreboard bench for multi_topology_adder: expected outputs are queued at drive time
// and popped one cycle later when the registered results appear.
module tb_multi_topology_adder;
  import adder_pkg::*;

  localparam int W = DEFAULT_DATA_WIDTH;

  typedef struct packed {
    logic        valid;
    add_result_t cla;
    add_result_t cka;
    add_result_t csa;
    logic        mismatch;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         valid_o, cla_carry_o, cka_carry_o, csa_carry_o, mismatch_o;
  logic [W-1:0] cla_result_o, cka_result_o, csa_result_o;

  obs_t        sb[$];
  add_result_t model_q = '0;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  multi_topology_adder dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .operand_A_i(a), .operand_B_i(b), .carry_i(cin),
    .valid_o(valid_o),
    .cla_result_o(cla_result_o), .cla_carry_o(cla_carry_o),
    .cka_result_o(cka_result_o), .cka_carry_o(cka_carry_o),
    .csa_result_o(csa_result_o), .csa_carry_o(csa_carry_o),
    .mismatch_o(mismatch_o)
  );

  function automatic obs_t sample();
    return {valid_o, cla_carry_o, cla_result_o, cka_carry_o, cka_result_o,
            csa_carry_o, csa_result_o, mismatch_o};
  endfunction

  // Drives one cycle of stimulus, queues its expected outcome, and returns just after the edge.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic c);
    obs_t e;
    @(negedge clk);
    rst   = r;
    valid = v;
    a     = aa;
    b     = bb;
    cin   = c;
    if (r) model_q = '0;
    else if (v) model_q = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
    e.valid    = v && !r;
    e.cla      = model_q;
    e.cka      = model_q;
    e.csa      = model_q;
    e.mismatch = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t exp, obs;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0001, 1'b1);
      exp = sb.pop_front();
      obs = sample();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_full_carry();
    obs_t exp, obs;
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    exp = sb.pop_front();
    obs = sample();
    tests_run++;
    if (obs !== exp || exp.cla !== {1'b1, 32'h0000_0000}) begin
      tests_failed++;
      $display("FAIL full_carry: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_signed_overflow();
    obs_t exp, obs;
    drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    exp = sb.pop_front();
    obs = sample();
    tests_run++;
    if (obs !== exp || exp.csa !== {1'b0, 32'h8000_0000}) begin
      tests_failed++;
      $display("FAIL signed_overflow: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_max_hold();
    obs_t exp, obs;
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    exp = sb.pop_front();
    obs = sample();
    tests_run++;
    if (obs !== exp || exp.cka !== {1'b1, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL max_operands: got %h expected %h", obs, exp);
    end
    drive(1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    exp = sb.pop_front();
    obs = sample();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL hold_idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp, obs;
    logic [W-1:0] va [3] = '{32'h0000_0005, 32'h0000_000F, 32'hDEAD_BEEF};
    logic [W-1:0] vb [3] = '{32'h0000_0003, 32'h0000_0001, 32'h1111_1111};
    logic         vc [3] = '{1'b0, 1'b1, 1'b1};
    logic         vr [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(vr[i], 1'b1, va[i], vb[i], vc[i]);
      exp = sb.pop_front();
      obs = sample();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    obs_t         exp, obs;
    logic [W-1:0] ra, rb;
    logic         rc, rv;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ~ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 7) != 0);
      drive(1'b0, rv, ra, rb, rc);
      exp = sb.pop_front();
      obs = sample();
      tests_run++;
      if (obs.cla !== exp.cla) begin
        tests_failed++;
        $display("FAIL random_cla[%0d]: got %h expected %h", i, obs.cla, exp.cla);
      end
      tests_run++;
      if (obs.cka !== exp.cka) begin
        tests_failed++;
        $display("FAIL random_cka[%0d]: got %h expected %h", i, obs.cka, exp.cka);
      end
      tests_run++;
      if (obs.csa !== exp.csa) begin
        tests_failed++;
        $display("FAIL random_csa[%0d]: got %h expected %h", i, obs.csa, exp.csa);
      end
      tests_run++;
      if (obs.valid !== exp.valid || obs.mismatch !== exp.mismatch) begin
        tests_failed++;
        $display("FAIL random_flags[%0d]: got valid=%b mismatch=%b expected valid=%b mismatch=%b",
                 i, obs.valid, obs.mismatch, exp.valid, exp.mismatch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_carry();
    test_signed_overflow();
    test_max_hold();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
